switch_pio_debounced: RTL

Parametrised Avalon-MM input-port slave for board switches and push-buttons. It synchronises a WIDTH-bit asynchronous input bus and debounces each bit independently. It captures qualifying edges per bit and raises a maskable level interrupt. The block sits on the Qsys system interconnect next to the motor-drive peripherals, which it serves as the read-only switch register set.

---
 rtl/switch_pio_debounced.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/switch_pio_debounced.sv
// ---------------------------------------------------------------------------
// switch_pio_debounced
//
// Read-only Avalon-MM input port for board switches and push-buttons.
// Each input bit is synchronised through two flops, debounced by its own
// counter, edge-detected and captured. Captured edges that are unmasked
// raise a registered level interrupt.
//
// Register map (address):
//   0 : debounced input value            (read only)
//   1 : interrupt mask, WIDTH bits       (read/write)
//   2 : raw synchronised input           (read only)
//   3 : edge capture                     (write 1 to clear per bit)
// Unused upper readdata bits read as zero.
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   DEBOUNCE_CYCLES clocks a synchronised bit must differ stably before the
//                   debounced value follows (>=1)
//   EDGE_MODE       0 rising, 1 falling, 2 (or above) both edges
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select
//   write      single-cycle write strobe
//   writedata  write data
//   readdata   registered read data, 1 clock after address
//   in_port    asynchronous switch inputs
//   irq        registered level interrupt
// ---------------------------------------------------------------------------
module switch_pio_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] deb_reg;
  logic [WIDTH-1:0] deb_next;
  logic [WIDTH-1:0] deb_d_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_next;
  logic [CNT_W-1:0] cnt_reg  [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             irq_reg;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] clr;
  logic             mask_wr;
  logic             wdata_unused;

  // Only the low WIDTH bits of writedata are meaningful.
  assign wdata_unused = ^writedata;

  // -------------------------------------------------------------------------
  // Per-bit debounce: the counter runs only while the synchronised input
  // disagrees with the debounced value; any agreement restarts it, so a
  // glitch shorter than DEBOUNCE_CYCLES never reaches deb.
  // -------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic differs;
    logic done;
    assign differs      = sync2_reg[gi] ^ deb_reg[gi];
    assign done         = differs && (cnt_reg[gi] == CNT_LAST);
    assign cnt_next[gi] = (!differs || done) ? '0 : cnt_reg[gi] + CNT_ONE;
    assign deb_next[gi] = done ? sync2_reg[gi] : deb_reg[gi];
  end

  // -------------------------------------------------------------------------
  // Edge qualification
  // -------------------------------------------------------------------------
  assign rise = deb_reg & ~deb_d_reg;
  assign fall = ~deb_reg & deb_d_reg;

  if (EDGE_MODE == 0) begin : g_edge_rise
    assign qual = rise;
  end else if (EDGE_MODE == 1) begin : g_edge_fall
    assign qual = fall;
  end else begin : g_edge_any
    assign qual = rise | fall;
  end

  // Clear first, then OR in new edges: a set in the same cycle wins.
  assign clr      = (write && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign cap_next = (cap_reg & ~clr) | qual;
  assign mask_wr  = write && (address == 2'd1);

  // -------------------------------------------------------------------------
  // Read mux (zero-extended)
  // -------------------------------------------------------------------------
  always_comb begin
    readdata_next = '0;
    case (address)
      2'd0:    readdata_next[WIDTH-1:0] = deb_reg;
      2'd1:    readdata_next[WIDTH-1:0] = mask_reg;
      2'd2:    readdata_next[WIDTH-1:0] = sync2_reg;
      default: readdata_next[WIDTH-1:0] = cap_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      deb_reg      <= '0;
      deb_d_reg    <= '0;
      mask_reg     <= '0;
      cap_reg      <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      sync1_reg    <= in_port;
      sync2_reg    <= sync1_reg;
      deb_reg      <= deb_next;
      deb_d_reg    <= deb_reg;
      cap_reg      <= cap_next;
      readdata_reg <= readdata_next;
      irq_reg      <= |(cap_reg & mask_reg);
      if (mask_wr) begin
        mask_reg <= writedata[WIDTH-1:0];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule
